// File: rtl/simt_core_sequencer_pkg.sv
// core_pkg: shared FSM state, NZP flag layout and types for the SIMT core sequencer.
package core_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE, DONE} state_t;
  localparam int NZP_N = 2;
  localparam int NZP_Z = 1;
  localparam int NZP_P = 0;
  typedef logic [2:0] nzp_t;
endpackage

// File: rtl/simt_core_sequencer_if.sv
// simt_core_sequencer_if: fetch, decode, LSU and status signals between the sequencer and its core.
interface simt_core_sequencer_if #(
  parameter int THREADS = 4,
  parameter int PC_BITS = 8
);
  logic                       start;
  logic [$clog2(THREADS):0]   thread_count;
  logic                       fetch_enable;
  logic                       fetch_done;
  logic                       is_nop;
  logic                       is_branch;
  logic                       is_cmp;
  logic                       is_alu;
  logic                       is_ldr;
  logic                       is_str;
  logic                       is_halt;
  logic [2:0]                 cond;
  logic [PC_BITS-1:0]         imm;
  logic [3*THREADS-1:0]       alu_nzp;
  logic [THREADS-1:0]         lsu_req;
  logic [THREADS-1:0]         lsu_done;
  logic [THREADS-1:0]         reg_we;
  logic [PC_BITS-1:0]         pc;
  logic [THREADS-1:0]         active_mask;
  logic                       done;
  logic                       error;
  modport master (
    input  start, thread_count, fetch_done, is_nop, is_branch, is_cmp, is_alu, is_ldr, is_str,
           is_halt, cond, imm, alu_nzp, lsu_done,
    output fetch_enable, lsu_req, reg_we, pc, active_mask, done, error
  );
  modport slave (
    output start, thread_count, fetch_done, is_nop, is_branch, is_cmp, is_alu, is_ldr, is_str,
           is_halt, cond, imm, alu_nzp, lsu_done,
    input  fetch_enable, lsu_req, reg_we, pc, active_mask, done, error
  );
endinterface

// File: rtl/simt_core_sequencer_nzp.sv
// nzp_branch_unit: per-thread NZP flags and the uniform branch-take reduction over active threads.
module nzp_branch_unit
  import core_pkg::*;
#(
  parameter int THREADS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we_i,
  input  logic [THREADS-1:0]     mask_i,
  input  logic [3*THREADS-1:0]   nzp_i,
  input  nzp_t                   cond_i,
  output logic                   take_o
);
  logic [THREADS-1:0] hit;
  for (genvar t = 0; t < THREADS; t++) begin : g_thr
    nzp_t nzp_q;
    always_ff @(posedge clk or posedge reset)
      if (reset) nzp_q <= '0;
      else if (we_i && mask_i[t]) nzp_q <= nzp_i[3*t +: 3];
    assign hit[t] = mask_i[t] & ((nzp_q[NZP_N] & cond_i[NZP_N]) |
                                 (nzp_q[NZP_Z] & cond_i[NZP_Z]) |
                                 (nzp_q[NZP_P] & cond_i[NZP_P]));
  end
  assign take_o = |hit;
endmodule

// File: rtl/simt_core_sequencer.sv
// simt_core_sequencer: fetch/decode/LSU-wait/execute/update sequencer owning the PC of a SIMT block.
module simt_core_sequencer
  import core_pkg::*;
#(
  parameter int THREADS     = 4,
  parameter int PC_BITS     = 8,
  parameter int LSU_TIMEOUT = 255
) (
  input logic                   clk,
  input logic                   reset,
  simt_core_sequencer_if.master bus
);
  localparam int TCW = $clog2(THREADS) + 1;
  localparam int CW  = LSU_TIMEOUT < 2 ? 1 : $clog2(LSU_TIMEOUT + 1);
  state_t             state_q, state_d;
  logic [PC_BITS-1:0] pc_q, pc_d, imm_q, imm_d;
  logic [THREADS-1:0] mask_q, mask_d, req_q, req_d, new_mask;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               br_q, br_d, cmp_q, cmp_d, wr_q, wr_d, mem_q, mem_d;
  nzp_t               cond_q, cond_d;
  logic [TCW-1:0]     tc;
  logic               all_done, timeout, take, unused;
  assign unused   = bus.is_nop;
  assign tc       = bus.thread_count > TCW'(THREADS) ? TCW'(THREADS) : bus.thread_count;
  for (genvar i = 0; i < THREADS; i++) begin : g_mask
    assign new_mask[i] = TCW'(i) < tc;
  end
  assign all_done = (bus.lsu_done & mask_q) == mask_q;
  assign timeout  = LSU_TIMEOUT != 0 && cnt_q == CW'(LSU_TIMEOUT - 1);
  nzp_branch_unit #(.THREADS(THREADS)) u_nzp (
    .clk    (clk),
    .reset  (reset),
    .we_i   (state_q == EXECUTE && cmp_q),
    .mask_i (mask_q),
    .nzp_i  (bus.alu_nzp),
    .cond_i (cond_q),
    .take_o (take)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      imm_q   <= '0;
      mask_q  <= '0;
      req_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      br_q    <= 1'b0;
      cmp_q   <= 1'b0;
      wr_q    <= 1'b0;
      mem_q   <= 1'b0;
      cond_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      mask_q  <= mask_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      br_q    <= br_d;
      cmp_q   <= cmp_d;
      wr_q    <= wr_d;
      mem_q   <= mem_d;
      cond_q  <= cond_d;
    end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    mask_d  = mask_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    br_d    = br_q;
    cmp_d   = cmp_q;
    wr_d    = wr_q;
    mem_d   = mem_q;
    cond_d  = cond_q;
    case (state_q)
      IDLE, DONE: if (bus.start) begin
        mask_d  = new_mask;
        pc_d    = '0;
        err_d   = 1'b0;
        state_d = FETCH;
      end
      FETCH: state_d = bus.fetch_done ? DECODE : FETCH;
      DECODE: begin
        br_d    = bus.is_branch;
        cmp_d   = bus.is_cmp;
        wr_d    = bus.is_alu | bus.is_ldr;
        mem_d   = bus.is_ldr | bus.is_str;
        cond_d  = bus.cond;
        imm_d   = bus.imm;
        state_d = bus.is_halt ? DONE : REQUEST;
      end
      REQUEST: begin
        req_d   = mem_q ? mask_q : '0;
        cnt_d   = '0;
        state_d = mem_q ? WAIT : EXECUTE;
      end
      // completion wins over a watchdog expiry landing in the same cycle
      WAIT: begin
        cnt_d   = cnt_q + 1'b1;
        req_d   = all_done || timeout ? '0 : req_q;
        err_d   = !all_done && timeout;
        state_d = all_done ? EXECUTE : timeout ? DONE : WAIT;
      end
      EXECUTE: state_d = UPDATE;
      UPDATE: begin
        pc_d    = br_q && take ? imm_q : pc_q + 1'b1;
        state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.fetch_enable = state_q == FETCH;
  assign bus.lsu_req      = req_q;
  assign bus.reg_we       = state_q == EXECUTE && wr_q ? mask_q : '0;
  assign bus.pc           = pc_q;
  assign bus.active_mask  = mask_q;
  assign bus.done         = state_q == DONE;
  assign bus.error        = err_q;
endmodule

// File: tb/tb_simt_core_sequencer.sv
// tb_simt_core_sequencer: directed and random instruction streams checked against an instruction-level model.
module tb_simt_core_sequencer;
  localparam int T  = 4;
  localparam int PB = 8;
  localparam int TO = 10;
  localparam logic [6:0] F_NOP = 7'h01, F_BR = 7'h02, F_CMP = 7'h04, F_ALU = 7'h08,
                         F_LDR = 7'h10, F_STR = 7'h20, F_HALT = 7'h40;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vec = 0;
  int bad = 0;
  logic [7:0] m_pc;
  logic [2:0] m_nzp [T];
  logic [3:0] m_mask;
  int         m_tc;
  simt_core_sequencer_if #(.THREADS(T), .PC_BITS(PB)) bus ();
  simt_core_sequencer #(.THREADS(T), .PC_BITS(PB), .LSU_TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive_flags(input logic [6:0] f, input logic [2:0] c, input logic [7:0] im,
                             input logic [11:0] nz);
    {bus.is_halt, bus.is_str, bus.is_ldr, bus.is_alu, bus.is_cmp, bus.is_branch, bus.is_nop} = f;
    bus.cond    = c;
    bus.imm     = im;
    bus.alu_nzp = nz;
  endtask
  task automatic start_block(input int tc);
    bus.start        = 1'b1;
    bus.thread_count = 3'(tc);
    @(negedge clk);
    bus.start = 1'b0;
    m_tc      = tc > T ? T : tc;
    m_mask    = 4'((1 << m_tc) - 1);
    m_pc      = '0;
    chk("start_mask", bus.active_mask, m_mask);
    chk("start_done", bus.done, 0);
    chk("start_err", bus.error, 0);
    chk("start_pc", bus.pc, 0);
  endtask
  // dl holds one byte per thread: the WAIT cycle on which that thread's lsu_done rises
  task automatic run_instr(input logic [6:0] f, input logic [2:0] c, input logic [7:0] im,
                           input logic [11:0] nz, input logic [31:0] dl, input int fd,
                           input int rst_at, output bit ended);
    int n, cyc, we_cnt, we_at, w, exp_end;
    bit mem, err, take, req_ok, we_ok;
    logic [3:0] ld;
    ended = 1'b0;
    for (int i = 0; i < 30 && !bus.fetch_enable; i++) @(negedge clk);
    chk("fetch_req", bus.fetch_enable, 1);
    chk("fetch_pc", bus.pc, m_pc);
    repeat (fd < 0 ? $urandom_range(0, 2) : fd) @(negedge clk);
    bus.fetch_done = 1'b1;
    drive_flags(f, c, im, nz);
    @(negedge clk);
    bus.fetch_done = 1'b0;
    chk("fetch_drop", bus.fetch_enable, 0);
    mem = f[4] | f[5];
    n = 1;
    for (int t = 0; t < m_tc; t++) if (int'(dl[8*t +: 8]) > n) n = int'(dl[8*t +: 8]);
    err = mem && !f[6] && n > TO;
    exp_end = f[6] ? 2 : err ? 3 + TO : 5 + (mem ? n : 0);
    cyc = 1; we_cnt = 0; we_at = 0; w = 0; req_ok = 1'b1; we_ok = 1'b1;
    while (cyc < 60) begin
      if (bus.reg_we != 0) begin
        we_cnt++;
        we_at = cyc;
        we_ok &= bus.reg_we == m_mask;
      end
      if (bus.lsu_req != 0) begin
        w++;
        req_ok &= bus.lsu_req == m_mask;
      end
      if (rst_at > 0 && w == rst_at) begin
        bus.lsu_done = '0;
        bus.start    = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_req", bus.lsu_req, 0);
        chk("rst_pc", bus.pc, 0);
        chk("rst_fetch", bus.fetch_enable, 0);
        chk("rst_mask", bus.active_mask, 0);
        chk("rst_done", bus.done, 0);
        @(negedge clk);
        reset = 1'b0;
        foreach (m_nzp[t]) m_nzp[t] = '0;
        ended = 1'b1;
        return;
      end
      for (int t = 0; t < T; t++) ld[t] = bus.lsu_req[t] && w >= int'(dl[8*t +: 8]);
      bus.lsu_done     = ld;
      bus.start        = $urandom_range(0, 3) == 0;
      bus.thread_count = 3'($urandom_range(0, 7));
      @(negedge clk);
      cyc++;
      if (bus.fetch_enable || bus.done) break;
    end
    bus.start    = 1'b0;
    bus.lsu_done = '0;
    chk("latency", cyc, exp_end);
    chk("we_cnt", we_cnt, (!f[6] && !err && (f[3] | f[4]) && m_mask != 0) ? 1 : 0);
    if (we_cnt == 1) chk("we_at", we_at, 3 + (mem ? n : 0));
    chk("we_val", we_ok, 1);
    chk("req_cnt", w, (mem && !f[6] && m_mask != 0) ? (err ? TO : n) : 0);
    chk("req_val", req_ok, 1);
    if (!f[6] && !err) begin
      if (f[2]) for (int t = 0; t < m_tc; t++) m_nzp[t] = nz[3*t +: 3];
      take = 1'b0;
      for (int t = 0; t < m_tc; t++) take = take | ((m_nzp[t] & c) != 0);
      m_pc = (f[1] && take) ? im : m_pc + 8'd1;
      chk("next_pc", bus.pc, m_pc);
    end else begin
      chk("done", bus.done, 1);
      chk("error", bus.error, err);
      chk("end_req", bus.lsu_req, 0);
      chk("end_pc", bus.pc, m_pc);
      ended = 1'b1;
    end
  endtask
  initial begin
    bit e;
    logic [6:0] f;
    logic [31:0] dl;
    int len;
    bus.start = 1'b0; bus.thread_count = '0; bus.fetch_done = 1'b0; bus.lsu_done = '0;
    drive_flags(7'h0, 3'h0, 8'h0, 12'h0);
    foreach (m_nzp[t]) m_nzp[t] = '0;
    repeat (2) @(negedge clk);
    chk("rst_pc0", bus.pc, 0);
    chk("rst_done0", bus.done, 0);
    chk("rst_err0", bus.error, 0);
    chk("rst_fetch0", bus.fetch_enable, 0);
    chk("rst_req0", bus.lsu_req, 0);
    chk("rst_we0", bus.reg_we, 0);
    chk("rst_mask0", bus.active_mask, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_fetch", bus.fetch_enable, 0);
    start_block(4);
    run_instr(F_ALU, 3'h0, 8'h00, 12'h0, 32'h0, 1, 0, e);
    run_instr(F_ALU, 3'h0, 8'h00, 12'h0, 32'h0, 1, 0, e);
    run_instr(F_HALT, 3'h0, 8'h00, 12'h0, 32'h0, 1, 0, e);
    start_block(4);
    run_instr(F_LDR, 3'h0, 8'h00, 12'h0, 32'h07050301, 1, 0, e);
    run_instr(F_HALT, 3'h0, 8'h00, 12'h0, 32'h0, 0, 0, e);
    start_block(2);
    run_instr(F_CMP, 3'h0, 8'h00, 12'b100_100_010_001, 32'h0, 1, 0, e);
    run_instr(F_BR, 3'b100, 8'h20, 12'h0, 32'h0, 1, 0, e);
    run_instr(F_HALT, 3'h0, 8'h00, 12'h0, 32'h0, 1, 0, e);
    start_block(4);
    run_instr(F_BR, 3'b100, 8'h40, 12'h0, 32'h0, 2, 0, e);
    run_instr(F_HALT, 3'h0, 8'h00, 12'h0, 32'h0, 1, 0, e);
    start_block(4);
    run_instr(F_CMP, 3'h0, 8'h00, 12'b010_010_010_010, 32'h0, 1, 0, e);
    run_instr(F_BR, 3'b010, 8'hFF, 12'h0, 32'h0, 1, 0, e);
    run_instr(F_ALU, 3'h0, 8'h00, 12'h0, 32'h0, 1, 0, e);
    run_instr(F_HALT, 3'h0, 8'h00, 12'h0, 32'h0, 1, 0, e);
    start_block(3);
    run_instr(F_CMP | F_BR, 3'b001, 8'h33, 12'b100_100_001, 32'h0, 0, 0, e);
    run_instr(F_HALT, 3'h0, 8'h00, 12'h0, 32'h0, 1, 0, e);
    start_block(4);
    run_instr(F_STR, 3'h0, 8'h00, 12'h0, 32'hFFFFFFFF, 1, 0, e);
    start_block(0);
    run_instr(F_LDR, 3'h0, 8'h00, 12'h0, 32'hFFFFFFFF, 1, 0, e);
    run_instr(F_BR, 3'b111, 8'h80, 12'h0, 32'h0, 1, 0, e);
    run_instr(F_ALU, 3'h0, 8'h00, 12'h0, 32'h0, 1, 0, e);
    run_instr(F_HALT, 3'h0, 8'h00, 12'h0, 32'h0, 1, 0, e);
    start_block(3);
    run_instr(F_ALU, 3'h0, 8'h00, 12'h0, 32'h0, 1, 0, e);
    run_instr(F_LDR, 3'h0, 8'h00, 12'h0, 32'hFFFFFFFF, 1, 3, e);
    start_block(4);
    run_instr(F_ALU, 3'h0, 8'h00, 12'h0, 32'h0, 1, 0, e);
    run_instr(F_HALT, 3'h0, 8'h00, 12'h0, 32'h0, 1, 0, e);
    for (int b = 0; b < 40; b++) begin
      start_block($urandom_range(0, 7));
      len = $urandom_range(3, 10);
      e = 1'b0;
      for (int i = 0; i < len && !e; i++) begin
        case ($urandom_range(0, 6))
          0: f = F_NOP;
          1: f = F_ALU;
          2: f = F_CMP;
          3: f = F_BR;
          4: f = F_LDR;
          5: f = F_STR;
          default: f = F_CMP | F_BR;
        endcase
        for (int t = 0; t < T; t++) dl[8*t +: 8] = $urandom_range(0, 15) == 0 ? 8'd12 : 8'($urandom_range(0, 8));
        run_instr(f, 3'($urandom), 8'($urandom), 12'($urandom), dl, -1, 0, e);
      end
      if (!e) run_instr(F_HALT, 3'h0, 8'h00, 12'h0, 32'h0, -1, 0, e);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
